// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Brief    : Time-multiplexed common-anode 7-segment scan controller with
//            dead-time blanking, frame-aligned load/ack and zero suppression.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_en,
    output logic [3:0]              nib_out,
    output logic                    seg_off,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    load_ack,
    output logic                    frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] c_cnt_max = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] c_blank   = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] c_idx_max = IW'(NUM_DIGITS - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    logic [0:0]            r_state;
    logic [IW-1:0]         r_idx;
    logic [CW-1:0]         r_cnt;
    logic [DW-1:0]         r_shadow;
    logic [DW-1:0]         r_pending;
    logic                  r_pend_v;

    logic [0:0]            w_state_nxt;
    logic [IW-1:0]         w_idx_nxt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [DW-1:0]         w_shadow_nxt;
    logic [DW-1:0]         w_pending_nxt;
    logic                  w_pend_v_nxt;
    logic                  w_slot_end;
    logic                  w_boundary;
    logic                  w_commit;
    logic                  w_zero_run;
    logic                  w_vis;
    logic [NUM_DIGITS-1:0] w_dark;
    logic [NUM_DIGITS-1:0] w_dig_en_nxt;
    logic [3:0]            w_nib_nxt;
    logic                  w_frame_done_nxt;

    // Slot/frame sequencing and the pending -> shadow handoff.
    always_comb begin
        w_slot_end    = (r_cnt == c_cnt_max);
        w_boundary    = w_slot_end && (r_idx == c_idx_max);
        w_cnt_nxt     = w_slot_end ? '0 : r_cnt + CW'(1);
        w_idx_nxt     = r_idx;
        if (w_slot_end) begin
            w_idx_nxt = (r_idx == c_idx_max) ? '0 : r_idx + IW'(1);
        end
        w_commit      = w_boundary && r_pend_v;
        w_shadow_nxt  = w_commit ? r_pending : r_shadow;
        w_pending_nxt = r_pending;
        w_pend_v_nxt  = r_pend_v;
        if (load) begin
            w_pending_nxt = data_in;
            w_pend_v_nxt  = 1'b1;
        end else if (w_commit) begin
            w_pend_v_nxt  = 1'b0;
        end

        case (r_state)
            ST_BLANK: w_state_nxt = (w_cnt_nxt == c_blank) ? ST_SHOW : ST_BLANK;
            ST_SHOW:  w_state_nxt = (w_cnt_nxt == '0) ? ST_BLANK : ST_SHOW;
            default:  w_state_nxt = ST_BLANK;
        endcase

        w_frame_done_nxt = (w_idx_nxt == c_idx_max) && (w_cnt_nxt == c_cnt_max);
    end

    // Outputs are computed from next-state values so they register alongside state/idx.
    always_comb begin
        w_zero_run   = 1'b1;
        w_dark       = '0;
        w_dig_en_nxt = '1;
        w_nib_nxt    = '0;
        w_vis        = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_zero_run = w_zero_run && (w_shadow_nxt[4*k +: 4] == 4'h0);
            w_dark[k]  = blank_mask[k] || (lz_en && (k > 0) && w_zero_run);
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IW'(k) == w_idx_nxt) begin
                w_nib_nxt       = w_shadow_nxt[4*k +: 4];
                w_vis           = (w_state_nxt == ST_SHOW) && !w_dark[k];
                w_dig_en_nxt[k] = !w_vis;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_BLANK;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_shadow   <= '0;
            r_pending  <= '0;
            r_pend_v   <= 1'b0;
            nib_out    <= 4'h0;
            seg_off    <= 1'b1;
            dig_en     <= '1;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shadow   <= w_shadow_nxt;
            r_pending  <= w_pending_nxt;
            r_pend_v   <= w_pend_v_nxt;
            nib_out    <= w_nib_nxt;
            seg_off    <= !w_vis;
            dig_en     <= w_dig_en_nxt;
            load_ack   <= w_commit;
            frame_done <= w_frame_done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Brief    : Self-checking bench for seg_scan_ctrl against a frame-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;
    localparam int F = N * R;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [15:0]   data_in;
    logic [3:0]    blank_mask;
    logic          lz_en;
    logic [3:0]    nib_out;
    logic          seg_off;
    logic [3:0]    dig_en;
    logic          load_ack;
    logic          frame_done;

    seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in),
        .blank_mask(blank_mask), .lz_en(lz_en), .nib_out(nib_out),
        .seg_off(seg_off), .dig_en(dig_en), .load_ack(load_ack),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          m_t;
    logic [15:0] m_shadow, m_pend;
    logic        m_pv, m_ack;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, m_t, obs, exp);
        end
    endtask

    // Expected outputs for cycle m_t, using the live inputs that were present at the edge.
    task automatic check_all(input logic [3:0] mk, input logic lz);
        int idx, pos;
        logic dark, show;
        logic [3:0] e_dig;
        idx   = (m_t / R) % N;
        pos   = m_t % R;
        dark  = mk[idx] || (lz && idx > 0 && (m_shadow >> (4 * idx)) == 16'h0);
        show  = (pos >= B) && !dark;
        e_dig = show ? ~(4'b0001 << idx) : 4'b1111;
        check("dig_en", 16'(dig_en), 16'(e_dig));
        check("seg_off", 16'(seg_off), 16'(!show));
        check("nib_out", 16'(nib_out), 16'(m_shadow[4*idx +: 4]));
        check("load_ack", 16'(load_ack), 16'(m_ack));
        check("frame_done", 16'(frame_done), 16'(m_t % F == F - 1));
    endtask

    task automatic tick();
        logic [3:0]  mk;
        logic        lz, ld;
        logic [15:0] d;
        mk = blank_mask; lz = lz_en; ld = load; d = data_in;
        @(posedge clk);
        #1;
        load  = 1'b0;
        m_ack = 1'b0;
        if ((m_t % F == F - 1) && m_pv) begin
            m_shadow = m_pend;
            m_pv     = 1'b0;
            m_ack    = 1'b1;
        end
        if (ld) begin
            m_pend = d;
            m_pv   = 1'b1;
        end
        m_t++;
        check_all(mk, lz);
    endtask

    task automatic run_to(input int n);
        while (m_t < n) tick();
    endtask

    task automatic model_reset();
        m_t = 0; m_shadow = '0; m_pend = '0; m_pv = 1'b0; m_ack = 1'b0;
    endtask

    task automatic load_at(input int n, input logic [15:0] v);
        run_to(n);
        load = 1'b1;
        data_in = v;
        tick();
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; data_in = '0; blank_mask = '0; lz_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all(blank_mask, lz_en);

        // Load lands mid-frame, commits at the frame boundary.
        load_at(5, 16'h1234);
        run_to(31);
        check("fd_31", 16'(frame_done), 16'd1);
        check("disp_old", 16'(nib_out), 16'h0);
        run_to(32);
        check("ack_32", 16'(load_ack), 16'd1);
        run_to(36);
        check("d0_dig", 16'(dig_en), 16'hE);
        check("d0_nib", 16'(nib_out), 16'h4);
        run_to(60);
        check("d3_dig", 16'(dig_en), 16'h7);
        check("d3_nib", 16'(nib_out), 16'h1);

        // Leading-zero suppression.
        run_to(40);
        lz_en = 1'b1;
        load_at(40, 16'h0050);
        run_to(68);
        check("lz_d0_dig", 16'(dig_en), 16'hE);
        check("lz_d0_nib", 16'(nib_out), 16'h0);
        load_at(70, 16'h0000);
        run_to(76);
        check("lz_d1_dig", 16'(dig_en), 16'hD);
        check("lz_d1_nib", 16'(nib_out), 16'h5);
        run_to(84);
        check("lz_d2_dig", 16'(dig_en), 16'hF);
        check("lz_d2_off", 16'(seg_off), 16'd1);
        run_to(100);
        check("lz0_d0_dig", 16'(dig_en), 16'hE);
        run_to(108);
        check("lz0_d1_dig", 16'(dig_en), 16'hF);

        // Blank mask on digit 1.
        lz_en = 1'b0;
        load_at(110, 16'h1234);
        run_to(127);
        blank_mask = 4'b0010;
        run_to(132);
        check("bm_d0_nib", 16'(nib_out), 16'h4);
        run_to(140);
        check("bm_d1_dig", 16'(dig_en), 16'hF);
        check("bm_d1_off", 16'(seg_off), 16'd1);
        run_to(148);
        check("bm_d2_dig", 16'(dig_en), 16'hB);
        check("bm_d2_nib", 16'(nib_out), 16'h2);

        // Latest load wins within a frame.
        run_to(159);
        blank_mask = 4'b0000;
        load_at(163, 16'hAAAA);
        load_at(170, 16'hBBBB);
        run_to(192);
        check("lw_ack", 16'(load_ack), 16'd1);
        run_to(196);
        check("lw_nib", 16'(nib_out), 16'hB);

        // Load on the boundary cycle while data is already pending.
        load_at(200, 16'h1357);
        load_at(223, 16'h2468);
        run_to(224);
        check("bd_ack1", 16'(load_ack), 16'd1);
        run_to(228);
        check("bd_nibA", 16'(nib_out), 16'h7);
        run_to(256);
        check("bd_ack2", 16'(load_ack), 16'd1);
        run_to(260);
        check("bd_nibB", 16'(nib_out), 16'h8);

        // Randomized traffic.
        while (m_t < 576) begin
            if ($urandom_range(0, 7) == 0) begin
                load = 1'b1;
                data_in = 16'($urandom);
                if ($urandom_range(0, 1) == 0) data_in = data_in & 16'h00FF;
            end
            if ($urandom_range(0, 15) == 0) blank_mask = 4'($urandom);
            if ($urandom_range(0, 15) == 0) lz_en = 1'($urandom);
            tick();
        end

        // Asynchronous reset mid-slot with data pending.
        blank_mask = '0;
        lz_en = 1'b0;
        while (m_t % F != 10) tick();
        load = 1'b1;
        data_in = 16'h9876;
        tick();
        while (m_t % F != 20) tick();
        #2;
        rst = 1'b1;
        #1;
        check("rst_dig", 16'(dig_en), 16'hF);
        check("rst_off", 16'(seg_off), 16'd1);
        check("rst_nib", 16'(nib_out), 16'h0);
        check("rst_ack", 16'(load_ack), 16'd0);
        check("rst_fd", 16'(frame_done), 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_all(blank_mask, lz_en);
        run_to(4);
        check("rr_d0_dig", 16'(dig_en), 16'hE);
        run_to(8);
        check("rr_d1_blank", 16'(dig_en), 16'hF);
        run_to(32);
        check("rr_no_ack", 16'(load_ack), 16'd0);
        run_to(70);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. All digits share one 4-bit-to-7-segment decoder. The block steps through the digits one at a time and presents each digit's nibble to the shared decoder. It drives the active-low digit enables, and inserts a dead-time blank between digits to suppress ghosting. New display values are accepted through a load/ack handshake and take effect only on a frame boundary, so a frame never shows a mix of old and new digits.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8); digit 0 is least significant.
REFRESH_DIV, 50000, clock cycles per digit slot; must be greater than BLANK_CYCLES.
BLANK_CYCLES, 500, dead-time cycles at the start of each slot (at least 1).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
load  in  1  single-cycle strobe; captures data_in
data_in  in  4*NUM_DIGITS  packed nibbles; bits [4k+3:4k] belong to digit k
blank_mask  in  NUM_DIGITS  1 = force digit k dark (sampled live)
lz_en  in  1  leading-zero suppression enable (sampled live)
nib_out  out  4  nibble to the shared seven-segment decoder
seg_off  out  1  1 = segment drivers must be forced off (all segments dark)
dig_en  out  NUM_DIGITS  active-low digit enables; at most one bit is low at any time
load_ack  out  1  one-cycle pulse when pending data is committed to the display
frame_done  out  1  one-cycle pulse on the last cycle of each full scan

Behaviour:
- Reset (async, rst=1):
  - state BLANK, idx=0, slot counter=0, shadow=0, pending=0, pend_v=0.
  - dig_en all ones, seg_off=1, nib_out=0, load_ack=0, frame_done=0.
- Slot timing:
  - The counter runs 0..REFRESH_DIV-1.
  - State is BLANK while cnt<BLANK_CYCLES and SHOW for the rest of the slot.
  - At cnt=REFRESH_DIV-1 the counter wraps to 0 and idx increments, wrapping from NUM_DIGITS-1 to 0.
  - Frame length is NUM_DIGITS*REFRESH_DIV cycles.
- Outputs:
  - All outputs are registered and update in the same cycle as the state and idx registers. There is no combinational path from any input to any output.
  - In BLANK: dig_en all ones, seg_off=1, nib_out holds the value of the upcoming digit.
  - In SHOW with the digit visible: dig_en[idx]=0 (all other bits 1), seg_off=0, nib_out=shadow nibble idx.
  - In SHOW with the digit dark: dig_en all ones, seg_off=1, nib_out=shadow nibble idx.
- Dark digit rules:
  - Digit k is dark if blank_mask[k]=1.
  - Digit k is also dark if lz_en=1, k>0, and shadow nibbles NUM_DIGITS-1 down to k are all zero.
  - Digit 0 is never suppressed by leading-zero suppression; it can still be darkened by blank_mask.
- Load handshake:
  - load=1 sets pending<=data_in and pend_v<=1. If pend_v is already 1, the latest load overwrites pending (latest wins).
- Frame boundary (idx=NUM_DIGITS-1 and cnt=REFRESH_DIV-1):
  - frame_done=1 for that cycle.
  - If pend_v=1: shadow<=pending, pend_v<=0, and load_ack=1 in the following cycle (the first cycle of digit 0's BLANK).
- Load on the boundary cycle:
  - If pend_v=1, the old pending value is committed and the new data_in is captured into pending; pend_v stays 1 and commits at the next boundary.
  - If pend_v=0, the new data is not committed this frame; it commits at the next boundary.
- Live inputs: blank_mask and lz_en changes take effect at the next registered update; no frame alignment is applied.
- Reset mid-slot: the block returns immediately to the reset state; pending data is lost and no load_ack is issued.

Test Plan:
(Use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2; frame = 32 cycles; cycle 0 = first clock after rst falls.)
1. Reset: assert rst during cycle 20 (digit 2 SHOW) -> dig_en=4'b1111, seg_off=1, nib_out=0 with no clock edge needed. After release, digit 0 SHOW occupies cycles 2..7, digit 1 BLANK occupies cycles 8..9, frame_done is high at cycle 31.
2. Load 16'h1234 at cycle 5 -> display unchanged through cycle 31 (shadow=0, lz_en=0, so all four digits show 0). load_ack=1 at cycle 32 only. Cycles 34..39: dig_en=4'b1110, nib_out=4. Cycles 58..63: dig_en=4'b0111, nib_out=1.
3. lz_en=1 with 16'h0050 committed -> digits 3 and 2 have dig_en=4'b1111 and seg_off=1 during SHOW; digit 1 shows 5; digit 0 shows 0. With 16'h0000 committed, only digit 0 lights, showing 0.
4. blank_mask=4'b0010 with 16'h1234 committed -> digit 1 slot stays dark (dig_en=4'b1111, seg_off=1); digits 0, 2, 3 show 4, 2, 1.
5. Loads A=16'hAAAA at cycle 3 and B=16'hBBBB at cycle 10 -> exactly one load_ack, at cycle 32; display shows B.
6. With A pending, load B exactly at cycle 31 -> load_ack at cycles 32 and 64; A is displayed in frame 2, B in frame 3; frame_done pulses every 32 cycles throughout.
